alien_bomb_object: RTL



---
 rtl/alien_bomb_object_if.sv | 30 +++
 rtl/alien_bomb_object.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alien_bomb_object_if.sv
// Frame, alien-matrix and bomb-position signals of alien_bomb_object.
// slave modport is the bomb block itself; master is the surrounding object layer.
interface alien_bomb_object_if #(
  parameter int NUM_BOMBS = 3,
  parameter int NUM_COLS  = 11
);
  // startOfFrame is a one-cycle strobe with no back-pressure; collision[i] is
  // level-sampled every clock; fired is a one-cycle strobe per bomb launched.
  logic                       startOfFrame;
  logic [NUM_COLS-1:0]        columnAlive;
  logic signed [10:0]         alienGridX;
  logic signed [10:0]         fireOriginY;
  logic [10:0]                playerPosX;
  logic [NUM_BOMBS-1:0]       collision;
  logic [NUM_BOMBS-1:0][10:0] topLeftX;
  logic [NUM_BOMBS-1:0][10:0] topLeftY;
  logic [NUM_BOMBS-1:0]       activeVec;
  logic                       fired;
  logic [1:0]                 dbgState;

  modport master (
    output startOfFrame, columnAlive, alienGridX, fireOriginY, playerPosX, collision,
    input  topLeftX, topLeftY, activeVec, fired, dbgState
  );

  modport slave (
    input  startOfFrame, columnAlive, alienGridX, fireOriginY, playerPosX, collision,
    output topLeftX, topLeftY, activeVec, fired, dbgState
  );
endinterface

// File: rtl/alien_bomb_object.sv
// Alien bomb launcher and mover: picks a living column, drops bombs, retires them.
// Define BOMB_AIMED_EN to aim every second launch at the column above the player.
module alien_bomb_object #(
  parameter int NUM_BOMBS       = 3,
  parameter int NUM_COLS        = 11,
  parameter int COL_PITCH_LOG2  = 5,
  parameter int BOMB_SPEED      = 160,
  parameter int FIRE_PERIOD_MIN = 20,
  parameter int BOTTOM_Y        = 470
) (
  input logic                clk,
  input logic                reset,
  alien_bomb_object_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEARCH = 2'd1, S_LAUNCH = 2'd2} state_t;

  state_t               state_q;
  logic [7:0]           timer_q;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [3:0]           cand_q, cand_next_d, start_col_d, rand_col_d;
  logic [3:0]           checks_q;
  logic [NUM_BOMBS-1:0] active_q;
  logic signed [31:0]   x_q [NUM_BOMBS];
  logic signed [31:0]   y_q [NUM_BOMBS];
  logic                 fired_q;
  logic                 any_free_d;
  int                   free_idx_d;
  int                   launch_px_d;
  logic signed [31:0]   launch_x_d, launch_y_d;
  logic                 unused_bits;

  always_comb begin
    lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    rand_col_d  = (lfsr_q[3:0] > 4'd10) ? lfsr_q[3:0] - 4'd5 : lfsr_q[3:0];
    cand_next_d = (cand_q == 4'(NUM_COLS - 1)) ? 4'd0 : cand_q + 4'd1;
    launch_px_d = int'(bus.alienGridX) + (int'(cand_q) << COL_PITCH_LOG2) + 14;
    launch_x_d  = launch_px_d * 64;
    launch_y_d  = int'(bus.fireOriginY) * 64;
  end

  // Lowest-index free slot wins the next launch.
  always_comb begin
    any_free_d = 1'b0;
    free_idx_d = 0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        any_free_d = 1'b1;
        free_idx_d = i;
      end
    end
  end

`ifdef BOMB_AIMED_EN
  logic       aim_q;
  int         aim_px_d;
  logic [3:0] aim_col_d;

  always_comb begin
    aim_px_d = int'(bus.playerPosX) + 16 - int'(bus.alienGridX);
    if (aim_px_d < 0)
      aim_col_d = 4'd0;
    else if ((aim_px_d >>> COL_PITCH_LOG2) > NUM_COLS - 1)
      aim_col_d = 4'(NUM_COLS - 1);
    else
      aim_col_d = 4'(aim_px_d >>> COL_PITCH_LOG2);
    start_col_d = aim_q ? aim_col_d : rand_col_d;
  end
`else
  always_comb start_col_d = rand_col_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= 8'(FIRE_PERIOD_MIN);
      lfsr_q   <= 16'hACE1;
      cand_q   <= 4'd0;
      checks_q <= 4'd0;
      active_q <= '0;
      fired_q  <= 1'b0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
`ifdef BOMB_AIMED_EN
      aim_q    <= 1'b0;
`endif
    end else begin
      lfsr_q  <= lfsr_d;
      fired_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.startOfFrame) begin
            if (timer_q != 8'd0) begin
              timer_q <= timer_q - 8'd1;
            end else if (any_free_d && (|bus.columnAlive)) begin
              cand_q   <= start_col_d;
              checks_q <= 4'd0;
              state_q  <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
          if (bus.columnAlive[cand_q]) begin
            state_q <= S_LAUNCH;
          end else if (checks_q == 4'(NUM_COLS - 1)) begin
            // Every column came up empty: the matrix died while we searched.
            state_q <= S_IDLE;
            timer_q <= 8'(FIRE_PERIOD_MIN);
          end else begin
            cand_q   <= cand_next_d;
            checks_q <= checks_q + 4'd1;
          end
        end
        S_LAUNCH: begin
          timer_q <= 8'(FIRE_PERIOD_MIN) + {3'd0, lfsr_q[4:0]};
          state_q <= S_IDLE;
          if (any_free_d) begin
            fired_q <= 1'b1;
`ifdef BOMB_AIMED_EN
            aim_q   <= ~aim_q;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Collision beats motion; a slot loading this cycle is inactive so it cannot move.
      for (int i = 0; i < NUM_BOMBS; i++) begin
        if (active_q[i]) begin
          if (bus.collision[i]) begin
            active_q[i] <= 1'b0;
          end else if (bus.startOfFrame) begin
            if (((y_q[i] + BOMB_SPEED) >>> 6) > BOTTOM_Y)
              active_q[i] <= 1'b0;
            else
              y_q[i] <= y_q[i] + BOMB_SPEED;
          end
        end else if (state_q == S_LAUNCH && any_free_d && i == free_idx_d) begin
          active_q[i] <= 1'b1;
          x_q[i]      <= launch_x_d;
          y_q[i]      <= launch_y_d;
        end
      end
    end
  end

  always_comb begin
    bus.topLeftX = '0;
    bus.topLeftY = '0;
    unused_bits  = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      bus.topLeftX[i] = x_q[i][16:6];
      bus.topLeftY[i] = y_q[i][16:6];
      unused_bits     = unused_bits ^ (^{x_q[i][31:17], x_q[i][5:0]});
    end
`ifndef BOMB_AIMED_EN
    unused_bits = unused_bits ^ (^bus.playerPosX);
`endif
  end

  assign bus.activeVec = active_q;
  assign bus.fired     = fired_q;
  assign bus.dbgState  = state_q;
endmodule
